spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter GuardCycles, default 2: idle cycles (0..15) inserted after a release before the next grant.
REQ-002 SHALL have port Clk_i, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port Reset_n_i, input, 1: reset; asynchronous, active-low.
REQ-004 SHALL have ports Req0_i / Req1_i, input, 1 each: client requests SPI master ownership; held high for the whole transaction.
REQ-005 SHALL have ports Grant0_o / Grant1_o, output, 1 each: ownership indication, one-hot or zero.
REQ-006 SHALL have ports Write0_i / Write1_i, input, 1 each: per-client SPI write strobes.
REQ-007 SHALL have ports ReadNext0_i / ReadNext1_i, input, 1 each: per-client SPI read strobes.
REQ-008 SHALL have ports Data0_i / Data1_i, input, 8 each: per-client transmit bytes.
REQ-009 SHALL have ports CPOL0_i / CPHA0_i / LSBFE0_i and CPOL1_i / CPHA1_i / LSBFE1_i, input, 1 each: per-client SPI mode.
REQ-010 SHALL have ports SPI_Write_o / SPI_ReadNext_o, output, 1 each: strobes to the shared SPI master.
REQ-011 SHALL have port SPI_Data_o, output, 8: transmit byte to the SPI master.
REQ-012 SHALL have ports SPI_CPOL_o / SPI_CPHA_o / SPI_LSBFE_o, output, 1 each: mode to the SPI master.
REQ-013 SHALL have ports SPI_Transmission_i / SPI_FIFOEmpty_i / SPI_FIFOFull_i, input, 1 each: SPI master status.
REQ-014 SHALL have port Busy_o, output, 1: high in every state except Idle.

Function
REQ-015 SHALL implement states Idle, Own0, Own1, Drain, Guard.
REQ-016 Idle SHALL grant a single requester the next cycle; on simultaneous requests it SHALL grant the client not granted last (round-robin).
REQ-017 SHALL keep the granted owner while its Req is high; the other client's Req SHALL be ignored during that time.
REQ-018 Owner's Req low SHALL move Own to Drain.
REQ-019 Drain SHALL exit when SPI_Transmission_i=0 and SPI_FIFOEmpty_i=1 in the same cycle: to Guard if GuardCycles>0, else to Idle.
REQ-020 Guard SHALL count GuardCycles cycles (4-bit counter), then go to Idle.
REQ-021 Grant SHALL be registered and high only in the matching Own state; grant latency from Req to Grant SHALL be 1 cycle from Idle.
REQ-022 SPI_Data_o and the mode outputs SHALL mux from the current/last owner, and SHALL hold that owner's values through Drain and Guard.
REQ-023 SPI_Write_o and SPI_ReadNext_o SHALL be combinational from the owner's strobes, gated by the owner's Grant.
REQ-024 SPI_Write_o SHALL additionally be gated by SPI_FIFOFull_i=0.
REQ-025 Strobes from a non-owner SHALL be dropped, never queued.
REQ-026 The last-grant register SHALL update on entry to Own0 or Own1.
REQ-027 A client that drops and re-raises Req during Drain or Guard SHALL be arbitrated in Idle normally.

Reset
REQ-028 Reset SHALL force: state Idle, last-grant=1 (client 0 wins the first tie), Grant0_o=Grant1_o=0, SPI_Write_o=SPI_ReadNext_o=0, SPI_Data_o=0x00, SPI_CPOL_o=SPI_CPHA_o=1, SPI_LSBFE_o=0, Busy_o=0, guard counter=0.
REQ-029 Reset asserted mid-transaction SHALL drop the grant immediately, with no drain.

Structure
REQ-030 The state enumeration, client count (2) and guard counter width (4) SHALL live in the shared SPI package.
REQ-031 The block SHALL be a single module; no sub-module is warranted.

Verification
REQ-032 Req0=1 alone from Idle -> Grant0_o=1 after 1 cycle; Write0_i pulse with Data0_i=0x50 -> SPI_Write_o=1 with SPI_Data_o=0x50 in the same cycle.
REQ-033 Req0 and Req1 rise in the same cycle after reset -> Grant0_o first. After release, Drain and 2 Guard cycles, both raised again -> Grant1_o.
REQ-034 Owner drops Req while SPI_Transmission_i=1 for 5 cycles -> Drain held 5 cycles, then Guard for 2 cycles, Busy_o=1 throughout, then Idle.
REQ-035 Client 1 pulses Write1_i while client 0 owns -> SPI_Write_o stays 0 and nothing is replayed later.
REQ-036 Owner strobes Write with SPI_FIFOFull_i=1 -> SPI_Write_o=0.
REQ-037 Reset_n_i low while in Own1 -> Grant1_o=0 asynchronously; after release, first tie goes to client 0.

Source files
------------

// File: rtl/spi_arbiter_pkg.sv
// Shared SPI arbitration types: arbiter states, client count, guard counter width,
// and the per-client SPI settings bundle with its reset value.
package spi_arbiter_pkg;

    localparam int NumClients    = 2;
    localparam int GuardCntWidth = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OWN0,
        ST_OWN1,
        ST_DRAIN,
        ST_GUARD
    } arb_state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       cpol;
        logic       cpha;
        logic       lsbfe;
    } spi_cfg_t;

    localparam spi_cfg_t CfgReset = '{data: 8'h00, cpol: 1'b1, cpha: 1'b1, lsbfe: 1'b0};

endpackage

// File: rtl/spi_arbiter.sv
// Two-client round-robin owner arbiter for a shared SPI master; grant 1 cycle after Req from Idle.
// Strobes pass combinationally from the granted owner only; writes are suppressed while the master FIFO is full.
module spi_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int GuardCycles = 2
) (
    input  logic       Clk_i,
    input  logic       Reset_n_i,
    input  logic       Req0_i,
    input  logic       Req1_i,
    output logic       Grant0_o,
    output logic       Grant1_o,
    input  logic       Write0_i,
    input  logic       Write1_i,
    input  logic       ReadNext0_i,
    input  logic       ReadNext1_i,
    input  logic [7:0] Data0_i,
    input  logic [7:0] Data1_i,
    input  logic       CPOL0_i,
    input  logic       CPHA0_i,
    input  logic       LSBFE0_i,
    input  logic       CPOL1_i,
    input  logic       CPHA1_i,
    input  logic       LSBFE1_i,
    output logic       SPI_Write_o,
    output logic       SPI_ReadNext_o,
    output logic [7:0] SPI_Data_o,
    output logic       SPI_CPOL_o,
    output logic       SPI_CPHA_o,
    output logic       SPI_LSBFE_o,
    input  logic       SPI_Transmission_i,
    input  logic       SPI_FIFOEmpty_i,
    input  logic       SPI_FIFOFull_i,
    output logic       Busy_o
);

    localparam logic [GuardCntWidth-1:0] GuardLast = GuardCntWidth'(GuardCycles - 1);

    arb_state_t               state;
    logic                     last_grant;
    logic [GuardCntWidth-1:0] guard_cnt;
    logic                     grant0;
    logic                     grant1;
    logic                     busy;
    spi_cfg_t                 held_cfg;
    spi_cfg_t                 cfg0;
    spi_cfg_t                 cfg1;
    spi_cfg_t                 live_cfg;

    assign cfg0 = '{data: Data0_i, cpol: CPOL0_i, cpha: CPHA0_i, lsbfe: LSBFE0_i};
    assign cfg1 = '{data: Data1_i, cpol: CPOL1_i, cpha: CPHA1_i, lsbfe: LSBFE1_i};

    // The owner's live settings pass straight through; once ownership ends the last snapshot is held.
    always_comb begin
        live_cfg = held_cfg;
        if (grant0) begin
            live_cfg = cfg0;
        end else if (grant1) begin
            live_cfg = cfg1;
        end
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            guard_cnt  <= '0;
            grant0     <= 1'b0;
            grant1     <= 1'b0;
            busy       <= 1'b0;
            held_cfg   <= CfgReset;
        end else begin
            case (state)
                ST_IDLE: begin
                    // On a tie, client 0 wins only if client 1 was granted last.
                    if (Req0_i && (!Req1_i || last_grant)) begin
                        state      <= ST_OWN0;
                        grant0     <= 1'b1;
                        busy       <= 1'b1;
                        last_grant <= 1'b0;
                    end else if (Req1_i) begin
                        state      <= ST_OWN1;
                        grant1     <= 1'b1;
                        busy       <= 1'b1;
                        last_grant <= 1'b1;
                    end
                end
                ST_OWN0: begin
                    held_cfg <= cfg0;
                    if (!Req0_i) begin
                        state  <= ST_DRAIN;
                        grant0 <= 1'b0;
                    end
                end
                ST_OWN1: begin
                    held_cfg <= cfg1;
                    if (!Req1_i) begin
                        state  <= ST_DRAIN;
                        grant1 <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (!SPI_Transmission_i && SPI_FIFOEmpty_i) begin
                        if (GuardCycles > 0) begin
                            state     <= ST_GUARD;
                            guard_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_GUARD: begin
                    if (guard_cnt == GuardLast) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        guard_cnt <= '0;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    grant0    <= 1'b0;
                    grant1    <= 1'b0;
                    busy      <= 1'b0;
                    guard_cnt <= '0;
                end
            endcase
        end
    end

    assign Grant0_o       = grant0;
    assign Grant1_o       = grant1;
    assign Busy_o         = busy;
    assign SPI_Write_o    = ((grant0 && Write0_i) || (grant1 && Write1_i)) && !SPI_FIFOFull_i;
    assign SPI_ReadNext_o = (grant0 && ReadNext0_i) || (grant1 && ReadNext1_i);
    assign SPI_Data_o     = live_cfg.data;
    assign SPI_CPOL_o     = live_cfg.cpol;
    assign SPI_CPHA_o     = live_cfg.cpha;
    assign SPI_LSBFE_o    = live_cfg.lsbfe;

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: directed vector table, corner-case sequences,
// and randomized traffic against an ownership-level reference model.
module tb_spi_arbiter;

    localparam int GUARD = 2;

    logic       Clk_i = 1'b0;
    logic       Reset_n_i = 1'b1;
    logic       req [2];
    logic       wr [2];
    logic       rd [2];
    logic [7:0] dat [2];
    logic       cpol [2];
    logic       cpha [2];
    logic       lsbfe [2];
    logic       trans, empty, full;

    logic       g0, g1, spi_wr, spi_rd, spi_cpol, spi_cpha, spi_lsbfe, busy;
    logic [7:0] spi_dat;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who holds the bus, drain/guard bookkeeping, last winner, held settings
    int         m_own;
    bit         m_drain;
    int         m_guard;
    int         m_last;
    logic [7:0] h_dat;
    logic       h_cpol, h_cpha, h_lsbfe;

    spi_arbiter #(.GuardCycles(GUARD)) dut (
        .Clk_i(Clk_i), .Reset_n_i(Reset_n_i),
        .Req0_i(req[0]), .Req1_i(req[1]),
        .Grant0_o(g0), .Grant1_o(g1),
        .Write0_i(wr[0]), .Write1_i(wr[1]),
        .ReadNext0_i(rd[0]), .ReadNext1_i(rd[1]),
        .Data0_i(dat[0]), .Data1_i(dat[1]),
        .CPOL0_i(cpol[0]), .CPHA0_i(cpha[0]), .LSBFE0_i(lsbfe[0]),
        .CPOL1_i(cpol[1]), .CPHA1_i(cpha[1]), .LSBFE1_i(lsbfe[1]),
        .SPI_Write_o(spi_wr), .SPI_ReadNext_o(spi_rd), .SPI_Data_o(spi_dat),
        .SPI_CPOL_o(spi_cpol), .SPI_CPHA_o(spi_cpha), .SPI_LSBFE_o(spi_lsbfe),
        .SPI_Transmission_i(trans), .SPI_FIFOEmpty_i(empty), .SPI_FIFOFull_i(full),
        .Busy_o(busy)
    );

    always #5 Clk_i = ~Clk_i;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_own   = -1;
        m_drain = 0;
        m_guard = 0;
        m_last  = 1;
        h_dat   = 8'h00;
        h_cpol  = 1'b1;
        h_cpha  = 1'b1;
        h_lsbfe = 1'b0;
    endtask

    task automatic model_edge();
        int w;
        if (m_own >= 0) begin
            h_dat   = dat[m_own];
            h_cpol  = cpol[m_own];
            h_cpha  = cpha[m_own];
            h_lsbfe = lsbfe[m_own];
            if (!req[m_own]) begin
                m_own   = -1;
                m_drain = 1;
            end
        end else if (m_drain) begin
            if (!trans && empty) begin
                m_drain = 0;
                m_guard = GUARD;
            end
        end else if (m_guard > 0) begin
            m_guard--;
        end else begin
            if (req[0] && req[1]) w = 1 - m_last;
            else if (req[0])      w = 0;
            else if (req[1])      w = 1;
            else                  w = -1;
            if (w >= 0) begin
                m_own  = w;
                m_last = w;
            end
        end
    endtask

    task automatic model_check(input string tag);
        logic [7:0] e_dat;
        logic e_cpol, e_cpha, e_lsbfe, e_wr, e_rd;
        e_dat = h_dat; e_cpol = h_cpol; e_cpha = h_cpha; e_lsbfe = h_lsbfe;
        e_wr = 1'b0; e_rd = 1'b0;
        if (m_own >= 0) begin
            e_dat = dat[m_own]; e_cpol = cpol[m_own]; e_cpha = cpha[m_own]; e_lsbfe = lsbfe[m_own];
            e_wr  = wr[m_own] && !full;
            e_rd  = rd[m_own];
        end
        chk({tag, ".grant0"}, {7'd0, g0}, {7'd0, m_own == 0});
        chk({tag, ".grant1"}, {7'd0, g1}, {7'd0, m_own == 1});
        chk({tag, ".busy"}, {7'd0, busy}, {7'd0, (m_own >= 0) || m_drain || (m_guard > 0)});
        chk({tag, ".write"}, {7'd0, spi_wr}, {7'd0, e_wr});
        chk({tag, ".readnext"}, {7'd0, spi_rd}, {7'd0, e_rd});
        chk({tag, ".data"}, spi_dat, e_dat);
        chk({tag, ".cpol"}, {7'd0, spi_cpol}, {7'd0, e_cpol});
        chk({tag, ".cpha"}, {7'd0, spi_cpha}, {7'd0, e_cpha});
        chk({tag, ".lsbfe"}, {7'd0, spi_lsbfe}, {7'd0, e_lsbfe});
    endtask

    task automatic step();
        @(posedge Clk_i);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        for (int c = 0; c < 2; c++) begin
            req[c] = 1'b0; wr[c] = 1'b0; rd[c] = 1'b0; dat[c] = 8'h00;
        end
        cpol[0] = 1'b0; cpha[0] = 1'b0; lsbfe[0] = 1'b1;
        cpol[1] = 1'b1; cpha[1] = 1'b0; lsbfe[1] = 1'b0;
        trans = 1'b0; empty = 1'b1; full = 1'b0;
    endtask

    // Called at posedge+1: reset is pulsed and released before the next edge
    task automatic apply_reset();
        Reset_n_i = 1'b0;
        model_reset();
        #2;
        Reset_n_i = 1'b1;
    endtask

    typedef struct packed {
        logic       r0, r1, w0, w1, fl, tr, em;
        logic [7:0] d0, d1;
        logic       eg0, eg1, ew, ebusy;
        logic [7:0] edat;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // r0 r1 w0 w1 full trans empty d0 d1 | g0 g1 wr busy data
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h50, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h50};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h51, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 8'h51};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h52, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 8'h52};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h53, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 8'h53};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h99, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 8'h53};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h99, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 8'h53};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h99, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 8'h53};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h99, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h53};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h99, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h99, 8'h3D, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3D};

        clear_inputs();
        #1;
        apply_reset();
        chk("reset.cpol", {7'd0, spi_cpol}, 8'd1);
        chk("reset.cpha", {7'd0, spi_cpha}, 8'd1);
        chk("reset.lsbfe", {7'd0, spi_lsbfe}, 8'd0);

        // Directed table: tie after reset, write pass-through, foreign/full strobes, drain, guard, round-robin
        for (int i = 0; i < 12; i++) begin
            req[0] = tbl[i].r0; req[1] = tbl[i].r1;
            wr[0] = tbl[i].w0; wr[1] = tbl[i].w1;
            full = tbl[i].fl; trans = tbl[i].tr; empty = tbl[i].em;
            dat[0] = tbl[i].d0; dat[1] = tbl[i].d1;
            #1;
            chk($sformatf("tbl%0d.grant0", i), {7'd0, g0}, {7'd0, tbl[i].eg0});
            chk($sformatf("tbl%0d.grant1", i), {7'd0, g1}, {7'd0, tbl[i].eg1});
            chk($sformatf("tbl%0d.write", i), {7'd0, spi_wr}, {7'd0, tbl[i].ew});
            chk($sformatf("tbl%0d.busy", i), {7'd0, busy}, {7'd0, tbl[i].ebusy});
            chk($sformatf("tbl%0d.data", i), spi_dat, tbl[i].edat);
            model_check($sformatf("tbl%0d", i));
            step();
        end

        // Drain held while the master is still transmitting, then the guard interval
        clear_inputs();
        apply_reset();
        req[0] = 1'b1; dat[0] = 8'h77;
        step();
        chk("drain.own", {7'd0, g0}, 8'd1);
        req[0] = 1'b0; trans = 1'b1; empty = 1'b0; dat[0] = 8'h11;
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("drain%0d.busy", i), {7'd0, busy}, 8'd1);
            chk($sformatf("drain%0d.grant0", i), {7'd0, g0}, 8'd0);
            chk($sformatf("drain%0d.data", i), spi_dat, 8'h11);
            model_check($sformatf("drain%0d", i));
            step();
        end
        trans = 1'b0; empty = 1'b1;
        chk("drain_exit.busy", {7'd0, busy}, 8'd1);
        step();
        for (int i = 0; i < GUARD; i++) begin
            chk($sformatf("guard%0d.busy", i), {7'd0, busy}, 8'd1);
            model_check($sformatf("guard%0d", i));
            step();
        end
        chk("idle.busy", {7'd0, busy}, 8'd0);

        // Reset in the middle of client 1's ownership
        clear_inputs();
        apply_reset();
        req[1] = 1'b1; wr[1] = 1'b1; dat[1] = 8'hC3;
        step();
        chk("own1.grant1", {7'd0, g1}, 8'd1);
        #2;
        Reset_n_i = 1'b0;
        model_reset();
        #1;
        chk("arst.grant1", {7'd0, g1}, 8'd0);
        chk("arst.busy", {7'd0, busy}, 8'd0);
        chk("arst.write", {7'd0, spi_wr}, 8'd0);
        chk("arst.data", spi_dat, 8'h00);
        chk("arst.cpol", {7'd0, spi_cpol}, 8'd1);
        #1;
        Reset_n_i = 1'b1;
        req[0] = 1'b1;
        step();
        chk("arst_tie.grant0", {7'd0, g0}, 8'd1);
        chk("arst_tie.grant1", {7'd0, g1}, 8'd0);

        // Randomized traffic against the reference model
        clear_inputs();
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(7) == 0) req[c] = ~req[c];
                wr[c]    = ($urandom_range(2) == 0);
                rd[c]    = ($urandom_range(2) == 0);
                dat[c]   = 8'($urandom);
                cpol[c]  = 1'($urandom);
                cpha[c]  = 1'($urandom);
                lsbfe[c] = 1'($urandom);
            end
            trans = 1'($urandom);
            empty = ($urandom_range(3) != 0);
            full  = ($urandom_range(3) == 0);
            #1;
            model_check("rand");
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
